// File: rtl/spi_mem_pkg.sv
// Shared opcodes, status value and FSM state encoding for the SPI SRAM responder.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_RDSR    = 8'h05;
  localparam logic [7:0] STATUS_VAL = 8'h40;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    STAT,
    IGNORE
  } state_t;

  // State entered once a full command byte has been shifted in.
  function automatic state_t decode_op(input logic [7:0] op);
    state_t nxt;
    case (op)
      OP_READ:  nxt = ADDR;
      OP_WRITE: nxt = ADDR;
      OP_RDSR:  nxt = STAT;
      default:  nxt = IGNORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_mem_responder_sync_edge.sv
// Two-flop synchronizer for a single asynchronous input, without edge detection.
module spi_mem_responder_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a one-clock edge detector.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Resetting to 0 means a cs_n held low across reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 serial SRAM responder (READ/WRITE/RDSR subset) with oversampled SPI pins.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 256
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   spi_cs_n,
  input  logic   spi_sclk,
  input  logic   spi_mosi,
  output logic   spi_miso,
  output logic   spi_miso_oe,
  output logic   busy,
  output state_t dbg_state_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_s1_q, mosi_s2_q;

  state_t            state_q;
  logic [4:0]        bit_cnt_q;
  logic [ADDR_W-1:0] rx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_q;
  logic              miso_q, oe_q, busy_q, is_wr_q, load_q;

  logic [7:0]        mem [MEM_WORDS];

  logic [ADDR_W-1:0] rx_d;
  logic [4:0]        bit_cnt_d;
  logic              byte_done;
  logic              wr_en;
  logic [7:0]        rd_data;

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi shares the sclk sync depth so the sampled bit lines up with the rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign rx_d      = {rx_q[ADDR_W-2:0], mosi_s2_q};
  assign bit_cnt_d = bit_cnt_q + 5'd1;
  assign byte_done = (bit_cnt_q == 5'd7);
  assign wr_en     = (state_q == WR_DATA) && sclk_rise && byte_done && !cs_rise;
  assign rd_data   = mem[addr_q[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_q[IDX_W-1:0]] <= rx_d[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      rx_q      <= '0;
      addr_q    <= '0;
      tx_q      <= 8'd0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      is_wr_q   <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (load_q) begin
        tx_q <= rd_data;
      end
      if (cs_rise) begin
        state_q   <= IDLE;
        bit_cnt_q <= 5'd0;
        miso_q    <= 1'b0;
        oe_q      <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q   <= CMD;
              busy_q    <= 1'b1;
              bit_cnt_q <= 5'd0;
              rx_q      <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_d;
              if (byte_done) begin
                bit_cnt_q <= 5'd0;
                state_q   <= decode_op(rx_d[7:0]);
                is_wr_q   <= (rx_d[7:0] == OP_WRITE);
                if (rx_d[7:0] == OP_RDSR) begin
                  tx_q <= STATUS_VAL;
                  oe_q <= 1'b1;
                end
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == 5'(ADDR_W - 1)) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= rx_d;
                if (is_wr_q) begin
                  state_q <= WR_DATA;
                end else begin
                  state_q <= RD_DATA;
                  oe_q    <= 1'b1;
                  load_q  <= 1'b1;
                end
              end
            end
          end
          RD_DATA: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_d;
              if (byte_done) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= addr_q + ADDR_W'(1);
                load_q    <= 1'b1;
              end
            end
            if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          WR_DATA: begin
            if (sclk_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_d;
              if (byte_done) begin
                bit_cnt_q <= 5'd0;
                addr_q    <= addr_q + ADDR_W'(1);
              end
            end
          end
          STAT: begin
            if (sclk_rise) begin
              bit_cnt_q <= bit_cnt_d;
              if (byte_done) begin
                bit_cnt_q <= 5'd0;
                tx_q      <= STATUS_VAL;
              end
            end
            if (sclk_fall) begin
              miso_q <= tx_q[7];
              tx_q   <= {tx_q[6:0], 1'b0};
            end
          end
          IGNORE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: an SPI master model drives pins; reads are checked against a byte-array memory model.
module tb_spi_mem_responder;
  import spi_mem_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   spi_cs_n, spi_sclk, spi_mosi;
  logic   spi_miso, spi_miso_oe, busy;
  state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int hp = 6;

  logic [7:0] ref_mem [256];
  logic [7:0] tx_buf  [256];
  logic [7:0] rx_buf  [256];
  logic [7:0] exp_q [$];
  int hdr_oe, data_oe;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    int          n;
    logic [23:0] exp_bytes;
    logic        exp_oe;
  } vec_t;
  vec_t vecs [7];

  spi_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master samples miso just before its rising edge, changes mosi after its falling edge.
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r, output int oe_ones);
    r = 8'd0;
    oe_ones = 0;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      wait_clks(hp);
      r = {r[6:0], spi_miso};
      oe_ones = oe_ones + (spi_miso_oe ? 1 : 0);
      spi_sclk = 1'b1;
      wait_clks(hp);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_txn(input logic [7:0] op, input logic [15:0] addr, input int nbytes);
    logic [7:0] r;
    int o;
    hdr_oe = 0;
    data_oe = 0;
    spi_cs_n = 1'b0;
    wait_clks(4);
    spi_byte(op, r, o);
    hdr_oe += o;
    if (op == OP_READ || op == OP_WRITE) begin
      spi_byte(addr[15:8], r, o);
      hdr_oe += o;
      spi_byte(addr[7:0], r, o);
      hdr_oe += o;
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(tx_buf[i], r, o);
      rx_buf[i] = r;
      data_oe += o;
    end
    wait_clks(hp);
    spi_cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic do_write(input logic [15:0] addr, input int n);
    spi_txn(OP_WRITE, addr, n);
    for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) & 255] = tx_buf[i];
  endtask

  task automatic do_read_check(input string name, input logic [15:0] addr, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(addr) + i) & 255]);
    for (int i = 0; i < n; i++) tx_buf[i] = 8'h00;
    spi_txn(OP_READ, addr, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_a%0h_b%0d", name, addr, i), 32'(rx_buf[i]), 32'(e));
    end
    check($sformatf("%s_oe_data", name), 32'(data_oe), 32'(8 * n));
    check($sformatf("%s_oe_hdr", name), 32'(hdr_oe), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int o;
    logic [15:0] ra;
    int rn;

    vecs[0] = '{op: OP_READ, addr: 16'h0010, n: 2, exp_bytes: 24'hA53C00, exp_oe: 1'b1};
    vecs[1] = '{op: OP_READ, addr: 16'h00FF, n: 3, exp_bytes: 24'h112233, exp_oe: 1'b1};
    vecs[2] = '{op: OP_READ, addr: 16'hFFFF, n: 2, exp_bytes: 24'h112200, exp_oe: 1'b1};
    vecs[3] = '{op: OP_READ, addr: 16'h0110, n: 2, exp_bytes: 24'hA53C00, exp_oe: 1'b1};
    vecs[4] = '{op: OP_RDSR, addr: 16'h0000, n: 2, exp_bytes: 24'h404000, exp_oe: 1'b1};
    vecs[5] = '{op: 8'h9F,   addr: 16'h0000, n: 2, exp_bytes: 24'h000000, exp_oe: 1'b0};
    vecs[6] = '{op: OP_READ, addr: 16'h0001, n: 1, exp_bytes: 24'h330000, exp_oe: 1'b1};

    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    wait_clks(3);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    wait_clks(6);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // Fill the whole store at the fastest legal sclk so every byte is known to the model.
    hp = 4;
    for (int i = 0; i < 256; i++) tx_buf[i] = 8'($urandom_range(0, 255));
    do_write(16'h0000, 256);

    hp = 6;
    tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C;
    do_write(16'h0010, 2);
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    do_write(16'h00FF, 3);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) tx_buf[i] = 8'h55;
      spi_txn(vecs[v].op, vecs[v].addr, vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++)
        check($sformatf("vec%0d_b%0d", v, i), 32'(rx_buf[i]), 32'(vecs[v].exp_bytes[23 - 8 * i -: 8]));
      check($sformatf("vec%0d_oe_data", v), 32'(data_oe), vecs[v].exp_oe ? 32'(8 * vecs[v].n) : 32'd0);
      check($sformatf("vec%0d_oe_hdr", v), 32'(hdr_oe), 32'd0);
    end

    // Unknown opcode followed by what would look like an address and data must not write.
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h10; tx_buf[2] = 8'h55; tx_buf[3] = 8'h55;
    spi_txn(8'h9F, 16'h0000, 4);
    check("ignore_oe", 32'(data_oe), 32'd0);
    do_read_check("ignore_mem", 16'h0010, 2);

    // Partial trailing byte is discarded; cs_n rise reaches IDLE after exactly 3 clk.
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00;
    do_write(16'h0020, 2);
    spi_cs_n = 1'b0;
    wait_clks(4);
    spi_byte(OP_WRITE, r, o);
    spi_byte(8'h00, r, o);
    spi_byte(8'h20, r, o);
    spi_byte(8'h77, r, o);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      wait_clks(hp);
      spi_sclk = 1'b1;
      wait_clks(hp);
      spi_sclk = 1'b0;
    end
    wait_clks(hp);
    spi_cs_n = 1'b1;
    wait_clks(2);
    check("cs_rise_lat_busy", 32'(busy), 32'd1);
    wait_clks(1);
    check("cs_rise_busy", 32'(busy), 32'd0);
    check("cs_rise_state", 32'(dbg_state), 32'(IDLE));
    ref_mem[8'h20] = 8'h77;
    wait_clks(6);
    do_read_check("partial", 16'h0020, 2);

    // Reset asserted with sclk high on the 4th data bit of a READ.
    spi_cs_n = 1'b0;
    wait_clks(4);
    spi_byte(OP_READ, r, o);
    spi_byte(8'h00, r, o);
    spi_byte(8'h10, r, o);
    for (int k = 0; k < 4; k++) begin
      spi_mosi = 1'b0;
      wait_clks(hp);
      spi_sclk = 1'b1;
      wait_clks(hp);
      if (k < 3) spi_sclk = 1'b0;
    end
    check("mid_rd_oe", 32'(spi_miso_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", 32'(spi_miso), 32'd0);
    check("mid_rst_oe", 32'(spi_miso_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    wait_clks(2);
    rst = 1'b0;
    spi_sclk = 1'b0;
    wait_clks(8);
    check("mid_rst_no_restart", 32'(busy), 32'd0);
    spi_cs_n = 1'b1;
    wait_clks(6);
    do_read_check("post_rst", 16'h0010, 1);

    // Fetch-style single-byte reads at the minimum sclk half period.
    hp = 4;
    for (int a = 0; a < 8; a++) do_read_check("fetch", 16'(a), 1);

    for (int t = 0; t < 30; t++) begin
      hp = $urandom_range(4, 7);
      ra = 16'($urandom_range(0, 65535));
      rn = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < rn; i++) tx_buf[i] = 8'($urandom_range(0, 255));
        do_write(ra, rn);
      end else begin
        do_read_check("rand", ra, rn);
      end
    end
    hp = 5;
    do_read_check("rand_final", 16'($urandom_range(0, 65535)), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
